// File: rtl/seq_pkg.sv
// Shared definitions for the sync-framed serial transmitter and its matching detector.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_PAR,
    ST_GAP
  } seq_state_t;

  localparam logic [3:0] SYNC_PAT = 4'b1011;
  localparam int         SYNC_LEN = 4;

  // Wide enough for DATA_W-1 (up to 31) and GAP_CYCLES-1 (up to 14).
  localparam int         CNT_W    = 5;

endpackage

// File: rtl/seq_tx_if.sv
// Payload handshake and serial output bundle for seq_tx.
interface seq_tx_if #(
  parameter int DATA_W = 8
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              x;
  logic              x_en;
  logic              done;

  modport master (
    output in_valid, in_data,
    input  in_ready, x, x_en, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, x, x_en, done
  );

endinterface

// File: rtl/seq_tx_shifter.sv
// Parallel-in serial-out register: load has priority over shift, MSB leaves first.
module seq_tx_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_shift,
  output logic              o_msb
);

  logic [DATA_W-1:0] r_sr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
      r_sr <= r_sr << 1;
    end
  end

  assign o_msb = r_sr[DATA_W-1];

endmodule

// File: rtl/seq_tx.sv
// Serial frame transmitter: 4'b1011 sync header, payload MSB first, then optional parity.
// Optional even-parity bit enabled by defining SEQ_TX_PARITY_EN.
module seq_tx
  import seq_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input logic     clk,
  input logic     rst,
  seq_tx_if.slave bus
);

  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam seq_state_t       POST_FRAME = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_x;
  logic             r_x_en;
  logic             r_done;
`ifdef SEQ_TX_PARITY_EN
  logic             r_par;
`endif

  logic             w_in_ready;
  logic             w_load;
  logic             w_shift;
  logic             w_msb;
  logic [1:0]       w_sync_idx;

  assign w_in_ready = (r_state == ST_IDLE);
  assign w_load     = w_in_ready & bus.in_valid;
  // The register shifts on the same edge its MSB is copied into r_x.
  assign w_shift    = ((r_state == ST_SYNC) && (r_cnt == '0)) ||
                      ((r_state == ST_DATA) && (r_cnt != '0));
  assign w_sync_idx = r_cnt[1:0] - 2'd1;

  seq_tx_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (bus.in_data),
    .i_shift (w_shift),
    .o_msb   (w_msb)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_x     <= 1'b0;
      r_x_en  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_state <= ST_SYNC;
            r_cnt   <= SYNC_LAST;
            r_x     <= SYNC_PAT[SYNC_LEN-1];
            r_x_en  <= 1'b1;
`ifdef SEQ_TX_PARITY_EN
            r_par   <= ^bus.in_data;
`endif
          end
        end
        ST_SYNC: begin
          if (r_cnt == '0) begin
            r_state <= ST_DATA;
            r_cnt   <= DATA_LAST;
            r_x     <= w_msb;
`ifndef SEQ_TX_PARITY_EN
            r_done  <= (DATA_W == 1);
`endif
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_x   <= SYNC_PAT[w_sync_idx];
          end
        end
        ST_DATA: begin
          if (r_cnt != '0) begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_x    <= w_msb;
`ifndef SEQ_TX_PARITY_EN
            r_done <= (r_cnt == CNT_W'(1));
`endif
          end else begin
`ifdef SEQ_TX_PARITY_EN
            r_state <= ST_PAR;
            r_x     <= r_par;
            r_done  <= 1'b1;
`else
            r_state <= POST_FRAME;
            r_cnt   <= GAP_LAST;
            r_x     <= 1'b0;
            r_x_en  <= 1'b0;
`endif
          end
        end
        ST_PAR: begin
          r_state <= POST_FRAME;
          r_cnt   <= GAP_LAST;
          r_x     <= 1'b0;
          r_x_en  <= 1'b0;
        end
        ST_GAP: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_x     <= 1'b0;
          r_x_en  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.x        = r_x;
  assign bus.x_en     = r_x_en;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_seq_tx.sv
// Bench for seq_tx: one instance with GAP_CYCLES=1, one with GAP_CYCLES=0, shared clock.
module tb_seq_tx;

  localparam int         GAP_A    = 1;
  localparam int         GAP_B    = 0;
  localparam int         TMO      = 200;
  localparam logic [3:0] SYNC_HDR = 4'b1011;

  typedef struct packed {
    logic x;
    logic done;
  } bit_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  int   tests      = 0;
  int   failed     = 0;
  int   gap_a      = 0;
  int   gap_b      = 0;
  int   last_gap_a = -1;
  int   last_gap_b = -1;
  bit_t qa[$];
  bit_t qb[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  seq_tx_if #(.DATA_W(8)) bus_a ();
  seq_tx_if #(.DATA_W(8)) bus_b ();

  seq_tx #(.DATA_W(8), .GAP_CYCLES(GAP_A)) u_dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  seq_tx #(.DATA_W(8), .GAP_CYCLES(GAP_B)) u_dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? bus_a.in_ready : bus_b.in_ready;
  endfunction

  function automatic logic last_bit(input int sel);
    return (sel == 0) ? (bus_a.x_en & bus_a.done) : (bus_b.x_en & bus_b.done);
  endfunction

  function automatic int qsize(input int sel);
    return (sel == 0) ? qa.size() : qb.size();
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin
      bus_a.in_valid = v;
      bus_a.in_data  = d;
    end else begin
      bus_b.in_valid = v;
      bus_b.in_data  = d;
    end
  endtask

  task automatic push_bit(input int sel, input logic x, input logic dn);
    bit_t b;
    b.x    = x;
    b.done = dn;
    if (sel == 0) qa.push_back(b);
    else          qb.push_back(b);
  endtask

  task automatic push_frame(input int sel, input logic [7:0] d, input logic p);
    for (int i = 3; i >= 0; i--) push_bit(sel, SYNC_HDR[i], 1'b0);
`ifdef SEQ_TX_PARITY_EN
    for (int i = 7; i >= 0; i--) push_bit(sel, d[i], 1'b0);
    push_bit(sel, p, 1'b1);
`else
    for (int i = 7; i >= 0; i--) push_bit(sel, d[i], (i == 0) && (p !== 1'bz));
`endif
  endtask

  task automatic mon(input int sel, input logic xen, input logic x, input logic dn);
    bit_t e;
    if (xen === 1'b1) begin
      if (qsize(sel) == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_bit dut%0d: x=%b done=%b, expected no frame bit at %0t",
                 sel, x, dn, $time);
      end else begin
        e = (sel == 0) ? qa.pop_front() : qb.pop_front();
        check($sformatf("frame_bit_dut%0d {x,done}", sel), {30'd0, x, dn}, {30'd0, e.x, e.done});
      end
      if (sel == 0) begin
        if (gap_a > 0) last_gap_a = gap_a;
        gap_a = 0;
      end else begin
        if (gap_b > 0) last_gap_b = gap_b;
        gap_b = 0;
      end
    end else begin
      check($sformatf("idle_out_dut%0d {x_en,x,done}", sel), {29'd0, xen, x, dn}, 32'd0);
      if (sel == 0) gap_a++;
      else          gap_b++;
    end
  endtask

  task automatic send(input int sel, input logic [7:0] d, input logic p, input bit hold);
    int n = 0;
    @(negedge clk);
    while (rdy(sel) !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) begin
      tests++;
      failed++;
      $display("FAIL ready_timeout dut%0d: in_ready stayed 0, expected 1", sel);
      return;
    end
    drive(sel, 1'b1, d);
    push_frame(sel, d, p);
    @(posedge clk);
    #1;
    if (sel == 0) check("latency_dut0 {x_en,x}", {30'd0, bus_a.x_en, bus_a.x}, 32'd3);
    else          check("latency_dut1 {x_en,x}", {30'd0, bus_b.x_en, bus_b.x}, 32'd3);
    drive(sel, hold, ~d);
  endtask

  task automatic wait_done(input int sel, input int gap);
    int n = 0;
    @(negedge clk);
    while (last_bit(sel) !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("done_seen_dut%0d", sel), (n < TMO) ? 32'd1 : 32'd0, 32'd1);
    for (int k = 0; k < gap; k++) begin
      @(negedge clk);
      check($sformatf("ready_in_gap_dut%0d", sel), {31'd0, rdy(sel)}, 32'd0);
    end
    @(negedge clk);
    check($sformatf("ready_after_gap_dut%0d", sel), {31'd0, rdy(sel)}, 32'd1);
    check($sformatf("queue_drained_dut%0d", sel), qsize(sel), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h3C, 1'b0};
    vecs[5] = '{8'h81, 1'b0};
    vecs[6] = '{8'h0E, 1'b1};
    vecs[7] = '{8'h5A, 1'b0};

    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    rst_a = 1'b0;
    rst_b = 1'b0;

    fork
      forever begin
        @(negedge clk);
        mon(0, bus_a.x_en, bus_a.x, bus_a.done);
        mon(1, bus_b.x_en, bus_b.x, bus_b.done);
      end
      begin
        #500000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    check("reset_dut0 {x,x_en,done,in_ready}",
          {28'd0, bus_a.x, bus_a.x_en, bus_a.done, bus_a.in_ready}, 32'd1);
    check("reset_dut1 {x,x_en,done,in_ready}",
          {28'd0, bus_b.x, bus_b.x_en, bus_b.done, bus_b.in_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      send(0, vecs[i].data, vecs[i].par, 1'b0);
      wait_done(0, GAP_A);
    end

    // Back-to-back with in_valid held high.
    last_gap_a = -1;
    send(0, 8'h01, 1'b1, 1'b1);
    send(0, 8'h80, 1'b1, 1'b0);
    wait_done(0, GAP_A);
    check("b2b_gap_dut0", last_gap_a, GAP_A + 1);

    // Reset asserted while the 6th frame bit is on x.
    send(0, 8'hC3, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_a = 1'b0;
    @(posedge clk);
    #1;
    check("abort_dut0 {x_en,done,in_ready}",
          {29'd0, bus_a.x_en, bus_a.done, bus_a.in_ready}, 32'd1);
    qa.delete();
    rst_a = 1'b1;
    send(0, 8'hFF, 1'b0, 1'b0);
    wait_done(0, GAP_A);

    send(1, 8'hA5, 1'b0, 1'b0);
    wait_done(1, GAP_B);
    last_gap_b = -1;
    send(1, 8'h01, 1'b1, 1'b1);
    send(1, 8'h80, 1'b1, 1'b0);
    wait_done(1, GAP_B);
    check("b2b_gap_dut1", last_gap_b, GAP_B + 1);
    send(1, 8'h07, 1'b1, 1'b0);
    wait_done(1, GAP_B);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
